// File: rtl/pc_pkg.sv
// Shared constants and command-priority decode for the PC sequencer.
package pc_pkg;

  localparam int          DATA_WIDTH_DEF   = 32;
  localparam logic [31:0] INIT_DEF         = 32'h0;
  localparam int          STEP_DEF         = 1;
  localparam int          OFFSET_WIDTH_DEF = 16;
  localparam int          RAS_DEPTH_DEF    = 4;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_REL,
    CMD_ABS,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  // Only one command runs per cycle: ret > call > load_abs > load_rel > inc_PC.
  function automatic cmd_e decode_cmd(input logic ret, input logic call,
                                      input logic load_abs, input logic load_rel,
                                      input logic inc_pc);
    if (ret)           return CMD_RET;
    else if (call)     return CMD_CALL;
    else if (load_abs) return CMD_ABS;
    else if (load_rel) return CMD_REL;
    else if (inc_pc)   return CMD_INC;
    else               return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = RAS_DEPTH_DEF,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic [PTR_W:0]        count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W:0]        count_q, count_d;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q != (PTR_W+1)'(DEPTH)) count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && count_q != '0) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; entries are only read after a push.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[ptr_q] <= push_data;
  end

  assign top   = mem[ptr_q - PTR_W'(1)];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: command priority decode, PC register and sticky RAS error.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] INIT         = DATA_WIDTH'(INIT_DEF),
  parameter int                    STEP         = STEP_DEF,
  parameter int                    OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int                    RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    inc_PC,
  input  logic                    load_abs,
  input  logic                    load_rel,
  input  logic                    call,
  input  logic                    ret,
  input  logic [DATA_WIDTH-1:0]   target,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0]   pc_out,
  output logic                    ras_empty,
  output logic                    ras_full,
  output logic                    ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  // Power-up value so pc_out reads INIT even before the first clear.
  logic [DATA_WIDTH-1:0] pc_q = INIT;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  err_q = 1'b0;
  logic                  err_d;

  cmd_e                  cmd;
  logic                  ras_push, ras_pop;
  logic [DATA_WIDTH-1:0] ras_top;
  logic [CNT_W-1:0]      ras_count;
  logic                  stk_full, stk_empty;
  logic [DATA_WIDTH-1:0] pc_next_seq;
  logic [DATA_WIDTH-1:0] offset_ext;

  assign pc_next_seq = pc_q + DATA_WIDTH'(STEP);
  assign offset_ext  = {{(DATA_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};

  always_comb begin
    cmd      = enable ? decode_cmd(ret, call, load_abs, load_rel, inc_PC) : CMD_NONE;
    pc_d     = pc_q;
    err_d    = err_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    unique case (cmd)
      CMD_RET: begin
        if (stk_empty) begin
          pc_d  = pc_next_seq;
          err_d = 1'b1;
        end else begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end
      end
      CMD_CALL: begin
        ras_push = 1'b1;
        pc_d     = target;
        if (stk_full) err_d = 1'b1;
      end
      CMD_ABS:  pc_d = target;
      CMD_REL:  pc_d = pc_q + offset_ext;
      CMD_INC:  pc_d = pc_next_seq;
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q  <= INIT;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_ras #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clear     (clear),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_next_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign pc_out    = pc_q;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic vs. a queue model.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        clear, enable, inc_PC, load_abs, load_rel, call, ret;
  logic [31:0] target;
  logic [15:0] offset;
  logic [31:0] pc_out, pc4_out;
  logic        ras_empty, ras_full, ras_err;
  logic        ras4_empty, ras4_full, ras4_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC value, stack as a bounded queue, sticky error bit.
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_ras[$];
  logic        m_err = 1'b0;

  always #5 clock = ~clock;

  pc_sequencer #(.STEP(1)) dut (
    .clock(clock), .clear(clear), .enable(enable), .inc_PC(inc_PC),
    .load_abs(load_abs), .load_rel(load_rel), .call(call), .ret(ret),
    .target(target), .offset(offset), .pc_out(pc_out),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  pc_sequencer #(.STEP(4)) dut4 (
    .clock(clock), .clear(clear), .enable(enable), .inc_PC(inc_PC),
    .load_abs(load_abs), .load_rel(load_rel), .call(call), .ret(ret),
    .target(target), .offset(offset), .pc_out(pc4_out),
    .ras_empty(ras4_empty), .ras_full(ras4_full), .ras_err(ras4_err)
  );

  task automatic idle();
    clear = 0; enable = 1; inc_PC = 0; load_abs = 0; load_rel = 0;
    call = 0; ret = 0; target = 32'h0; offset = 16'h0;
  endtask

  task automatic model_step();
    if (clear) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_err = 1'b0;
    end else if (enable) begin
      if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = m_pc + 1; m_err = 1'b1; end
      end else if (call) begin
        if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_err = 1'b1; end
        m_ras.push_back(m_pc + 1);
        m_pc = target;
      end else if (load_abs) m_pc = target;
      else if (load_rel)     m_pc = m_pc + 32'($signed(offset));
      else if (inc_PC)       m_pc = m_pc + 1;
    end
  endtask

  // Advance one clock with the currently driven inputs, then return inputs to idle.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic test_pre_reset();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++; $display("FAIL pre_reset_pc: got %h expected %h", pc_out, 32'h0);
    end
  endtask

  task automatic test_reset();
    load_abs = 1; target = 32'h55; tick();
    call = 1; target = 32'h77; tick();
    clear = 1; call = 1; ret = 1; target = 32'h1234; tick();
    n_checks++;
    if (pc_out !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got pc=%h e=%b f=%b err=%b expected pc=0 e=1 f=0 err=0",
               pc_out, ras_empty, ras_full, ras_err);
    end
  endtask

  task automatic test_inc_step4();
    logic [31:0] exp4;
    clear = 1; tick();
    for (int i = 0; i < 4; i++) begin
      exp4 = 32'(4 * i);
      n_checks++;
      if (pc4_out !== exp4) begin
        n_fail++; $display("FAIL inc_step4[%0d]: got %h expected %h", i, pc4_out, exp4);
      end
      if (i < 3) begin inc_PC = 1; tick(); end
    end
  endtask

  task automatic test_rel_abs_wrap();
    clear = 1; tick();
    load_abs = 1; target = 32'h100; tick();
    load_rel = 1; offset = 16'hFFF0; tick();
    n_checks++;
    if (pc_out !== 32'hF0) begin
      n_fail++; $display("FAIL load_rel_neg: got %h expected %h", pc_out, 32'hF0);
    end
    load_abs = 1; target = 32'hFFFF_FFFF; tick();
    inc_PC = 1; tick();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++; $display("FAIL inc_wrap: got %h expected %h", pc_out, 32'h0);
    end
  endtask

  task automatic test_call_ret();
    clear = 1; tick();
    load_abs = 1; target = 32'h10; tick();
    call = 1; target = 32'h200; tick();
    n_checks++;
    if (pc_out !== 32'h200 || ras_empty !== 1'b0) begin
      n_fail++; $display("FAIL call: got pc=%h e=%b expected pc=200 e=0", pc_out, ras_empty);
    end
    ret = 1; tick();
    n_checks++;
    if (pc_out !== 32'h11 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret: got pc=%h e=%b expected pc=11 e=1", pc_out, ras_empty);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret;
    clear = 1; tick();
    for (int i = 0; i < 5; i++) begin
      call = 1; target = 32'h1000 * (i + 1); tick();
      if (i == 3) begin
        n_checks++;
        if (ras_full !== 1'b1 || ras_err !== 1'b0) begin
          n_fail++; $display("FAIL fill4: got f=%b err=%b expected f=1 err=0", ras_full, ras_err);
        end
      end
    end
    n_checks++;
    if (ras_full !== 1'b1 || ras_err !== 1'b1) begin
      n_fail++; $display("FAIL overflow: got f=%b err=%b expected f=1 err=1", ras_full, ras_err);
    end
    for (int i = 4; i >= 1; i--) begin
      ret = 1; tick();
      exp_ret = 32'h1000 * i + 1;
      n_checks++;
      if (pc_out !== exp_ret) begin
        n_fail++; $display("FAIL overflow_ret[%0d]: got %h expected %h", i, pc_out, exp_ret);
      end
    end
    n_checks++;
    if (ras_empty !== 1'b1 || ras_err !== 1'b1) begin
      n_fail++; $display("FAIL drained: got e=%b err=%b expected e=1 err=1", ras_empty, ras_err);
    end
  endtask

  task automatic test_underflow_priority();
    clear = 1; tick();
    load_abs = 1; target = 32'h40; tick();
    ret = 1; tick();
    n_checks++;
    if (pc_out !== 32'h41 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL underflow: got pc=%h err=%b e=%b expected pc=41 err=1 e=1",
                         pc_out, ras_err, ras_empty);
    end
    call = 1; target = 32'h80; tick();
    ret = 1; call = 1; inc_PC = 1; load_abs = 1; target = 32'h999; tick();
    n_checks++;
    if (pc_out !== 32'h42 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL priority: got pc=%h e=%b expected pc=42 e=1", pc_out, ras_empty);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    clear = 1; tick();
    load_abs = 1; target = 32'h321; tick();
    call = 1; target = 32'h500; tick();
    held = 32'h500;
    for (int i = 0; i < 2; i++) begin enable = 0; inc_PC = 1; tick(); end
    enable = 0; ret = 1; tick();
    n_checks++;
    if (pc_out !== held || ras_empty !== 1'b0) begin
      n_fail++; $display("FAIL stall: got pc=%h e=%b expected pc=%h e=0", pc_out, ras_empty, held);
    end
    clear = 1; call = 1; target = 32'hABC; tick();
    n_checks++;
    if (pc_out !== 32'h0 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
      n_fail++; $display("FAIL clear_with_call: got pc=%h e=%b err=%b expected pc=0 e=1 err=0",
                         pc_out, ras_empty, ras_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(0, 39) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      ret      = ($urandom_range(0, 4) == 0);
      call     = ($urandom_range(0, 3) == 0);
      load_abs = ($urandom_range(0, 5) == 0);
      load_rel = ($urandom_range(0, 4) == 0);
      inc_PC   = ($urandom_range(0, 1) == 0);
      target   = $urandom;
      offset   = 16'($urandom);
      tick();
      n_checks++;
      if (pc_out !== m_pc || ras_empty !== (m_ras.size() == 0) ||
          ras_full !== (m_ras.size() == 4) || ras_err !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc=%h e=%b f=%b err=%b expected pc=%h e=%b f=%b err=%b",
                 i, pc_out, ras_empty, ras_full, ras_err,
                 m_pc, (m_ras.size() == 0), (m_ras.size() == 4), m_err);
      end
    end
  endtask

  initial begin
    idle();
    enable = 0;
    #1;
    test_pre_reset();
    idle();
    test_reset();
    test_inc_step4();
    test_rel_abs_wrap();
    test_call_ret();
    test_overflow();
    test_underflow_priority();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter INIT, default 32'h0: PC value after reset.
REQ-003 Parameter STEP, default 1: increment added by inc_PC and by the call return-address computation.
REQ-004 Parameter OFFSET_WIDTH, default 16: width of the signed relative-branch offset.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 clear  input  1  reset; synchronous, active-high.
REQ-008 enable  input  1  when low, all state holds (stall).
REQ-009 inc_PC  input  1  advance PC by STEP.
REQ-010 load_abs  input  1  PC <= target.
REQ-011 load_rel  input  1  PC <= PC + sign-extended offset.
REQ-012 call  input  1  push PC+STEP onto the RAS, then PC <= target.
REQ-013 ret  input  1  pop the RAS top into PC.
REQ-014 target  input  DATA_WIDTH  absolute destination for load_abs and call.
REQ-015 offset  input  OFFSET_WIDTH  two's-complement relative displacement.
REQ-016 pc_out  output  DATA_WIDTH  current PC, driven directly from a register.
REQ-017 ras_empty  output  1  RAS holds 0 entries.
REQ-018 ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-019 ras_err  output  1  sticky flag for RAS overflow or underflow.

Function
REQ-020 When several commands are asserted in one cycle, only one is executed, in this priority: ret > call > load_abs > load_rel > inc_PC.
REQ-021 With enable high and no command asserted, PC, RAS and all flags hold.
REQ-022 With enable low, every command is ignored and all state holds.
REQ-023 Every command takes effect on the next rising edge; pc_out shows the new value one cycle after the command is sampled.
REQ-024 All PC arithmetic wraps modulo 2^DATA_WIDTH.
REQ-025 offset is sign-extended to DATA_WIDTH before it is added.
REQ-026 call with count < RAS_DEPTH: push pc_out+STEP, increment count, PC <= target.
REQ-027 call with the RAS full:
- the oldest entry is overwritten (circular buffer);
- count stays at RAS_DEPTH;
- ras_err is set;
- PC <= target.
REQ-028 ret with count > 0: PC <= top entry, decrement count.
REQ-029 ret with the RAS empty: PC <= pc_out+STEP, count stays 0, ras_err is set.
REQ-030 ras_empty and ras_full are decoded from the registered count and are valid in the same cycle as pc_out.
REQ-031 ras_err, once set, stays set until clear.

Reset
REQ-032 clear high at a rising edge sets:
- pc_out = INIT;
- RAS count = 0, so ras_empty=1 and ras_full=0;
- ras_err = 0.
REQ-033 clear overrides enable and every command in the same cycle, including a call or ret in progress.
REQ-034 RAS storage contents are not reset; an entry is readable only after it has been pushed.
REQ-035 For simulation, pc_out holds INIT before the first clear.

Structure
REQ-036 The command-priority encoding and the default parameter constants belong in a shared package, pc_pkg.
REQ-037 The return-address stack is a sub-module, pc_ras, with this contract:
- inputs: push, pop, push_data;
- outputs: top, count, full, empty;
- push and pop in the same cycle is never issued by pc_sequencer.
REQ-038 pc_sequencer contains only the command priority decode, the PC register and the ras_err register.

Verification
REQ-039 clear, then inc_PC for 3 cycles with STEP=4 -> pc_out sequence 0, 4, 8, 12.
REQ-040 pc_out=0x100, load_rel with offset=16'hFFF0 -> pc_out=0xF0; then load_abs with target=0xFFFFFFFF followed by inc_PC (STEP=1) -> pc_out=0x0 (wrap).
REQ-041 pc_out=0x10, call with target=0x200 -> pc_out=0x200 and ras_empty=0; then ret -> pc_out=0x11 and ras_empty=1.
REQ-042 Five calls with RAS_DEPTH=4 -> ras_full=1 and ras_err=1; then four rets return the four newest return addresses, after which ras_empty=1.
REQ-043 ret on an empty RAS at pc_out=0x40 -> pc_out=0x41 and ras_err=1; ret, call and inc_PC asserted together -> only ret executes.
REQ-044 enable=0 with inc_PC=1 for 2 cycles -> pc_out unchanged; clear asserted together with a call -> pc_out=INIT, ras_empty=1, ras_err=0.
